// File: rtl/ro_puf_reader.sv
// Ring-oscillator PUF reader: enables a pair of ring oscillators, lets them
// settle, counts rising edges of each over a programmable window of clk
// cycles and reports one response bit from comparing the two counts.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             request a measurement (sampled only when idle)
//   window            window length in clk cycles, captured on start
//   osc_a, osc_b      ring oscillator outputs, asynchronous to clk
//   en_a, en_b        ring oscillator enables
//   busy              high from start acceptance through the done cycle
//   done              one-cycle pulse, results valid
//   count_a, count_b  edges counted in the window (saturating)
//   response          count_a > count_b
//   tie               count_a == count_b
//   saturated         a counter reached all-ones during the window
module ro_puf_reader #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WIN_W  = 16,
  parameter int unsigned SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             osc_a,
  input  logic             osc_b,
  output logic             en_a,
  output logic             en_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             response,
  output logic             tie,
  output logic             saturated
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync_a, sync_b;  // [1:0] synchronizer, [2] history
  logic             edge_a, edge_b;
  logic [WIN_W-1:0] win_q;
  logic [TMR_W-1:0] tmr;
  logic             tmr_zero;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;

  // Free-running synchronizers and history flops for both rings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], osc_a};
      sync_b <= {sync_b[1:0], osc_b};
    end
  end

  assign edge_a   = sync_a[1] & ~sync_a[2];
  assign edge_b   = sync_b[1] & ~sync_b[2];
  assign tmr_zero = (tmr == '0);

  // Saturating edge counters, advancing only inside the window
  always_comb begin
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    if (state == S_COUNT) begin
      if (edge_a && (cnt_a != CNT_MAX)) cnt_a_nxt = cnt_a + CNT_W'(1);
      if (edge_b && (cnt_b != CNT_MAX)) cnt_b_nxt = cnt_b + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (tmr_zero) state_nxt = (win_q != '0) ? S_COUNT : S_DONE;
      S_COUNT:  if (tmr_zero) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register and control outputs, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      en_a  <= 1'b0;
      en_b  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      en_a  <= (state_nxt == S_SETTLE) || (state_nxt == S_COUNT);
      en_b  <= (state_nxt == S_SETTLE) || (state_nxt == S_COUNT);
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Window capture, phase timer, counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      tmr       <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      count_a   <= '0;
      count_b   <= '0;
      response  <= 1'b0;
      tie       <= 1'b0;
      saturated <= 1'b0;
    end else begin
      cnt_a <= cnt_a_nxt;
      cnt_b <= cnt_b_nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            win_q     <= window;
            tmr       <= TMR_W'(SETTLE - 1);
            cnt_a     <= '0;
            cnt_b     <= '0;
            count_a   <= '0;
            count_b   <= '0;
            response  <= 1'b0;
            tie       <= 1'b0;
            saturated <= 1'b0;
          end
        end
        S_SETTLE: begin
          // Timer reloads with the window length as the settle phase ends
          tmr <= tmr_zero ? (TMR_W'(win_q) - TMR_W'(1)) : (tmr - TMR_W'(1));
        end
        S_COUNT: begin
          tmr <= tmr - TMR_W'(1);
          if ((cnt_a_nxt == CNT_MAX) || (cnt_b_nxt == CNT_MAX)) saturated <= 1'b1;
        end
        default: ;
      endcase
      // Results are latched on the edge that enters DONE
      if (state_nxt == S_DONE) begin
        count_a  <= cnt_a_nxt;
        count_b  <= cnt_b_nxt;
        response <= (cnt_a_nxt > cnt_b_nxt);
        tie      <= (cnt_a_nxt == cnt_b_nxt);
      end
    end
  end

endmodule

// File: doc/ro_puf_reader.md
Name: ro_puf_reader

Overview:
- Measurement end of the ring-oscillator path: the reader for a pair of ring-oscillator instances.
- Drives their enable inputs and counts rising edges of each oscillator output over a programmable window of clk cycles.
- Produces one PUF response bit from comparing the two counts.
- Sits between the oscillator pair and the Root-of-Trust key/response collection logic.

Parameters:
- CNT_W, 16, width of each edge counter and count output.
- WIN_W, 16, width of the window input.
- SETTLE, 8, clk cycles the rings run, enabled but uncounted, before the window opens (≥3).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a measurement; sampled only in IDLE.
- window  input  WIN_W  measurement length in clk cycles; captured when start is accepted.
- osc_a  input  1  output of ring oscillator A; asynchronous to clk.
- osc_b  input  1  output of ring oscillator B; asynchronous to clk.
- en_a  output  1  enable to ring A.
- en_b  output  1  enable to ring B.
- busy  output  1  high from start acceptance through DONE.
- done  output  1  one-cycle pulse; results valid.
- count_a  output  CNT_W  rising edges of osc_a counted in the window.
- count_b  output  CNT_W  rising edges of osc_b counted in the window.
- response  output  1  1 iff count_a > count_b.
- tie  output  1  1 iff count_a == count_b.
- saturated  output  1  either counter hit all-ones during the window.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; counters, window register and synchronizers 0. Reset mid-measurement aborts immediately; en_a/en_b drop asynchronously; no done is issued.
- Input conditioning: each osc passes through a 2-flop synchronizer plus one history flop, all running continuously. Rising edge = sync2 & ~hist. Edges are counted only in COUNT. Valid only for f_osc < f_clk/2; faster rings alias, and this is a documented limitation.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - start=1 at edge k → SETTLE.
  - en_a=en_b=1 from edge k.
  - Capture window.
  - Clear counters, count outputs, response, tie and saturated.
  - busy=1 from edge k.
- SETTLE: lasts exactly SETTLE cycles, which primes the synchronizers and history. Then go to COUNT if window≠0, else to DONE.
- COUNT:
  - Lasts exactly window cycles.
  - Each cycle, each counter increments by 1 per detected edge.
  - Counters saturate at 2^CNT_W−1; reaching it sets saturated (sticky until next start).
  - Then go to DONE.
- DONE:
  - Exactly one cycle: done=1, en_a=en_b=0.
  - count_a/count_b, response and tie are registered valid during this cycle.
  - Next state IDLE, busy=0.
- Timing: done is high between edges k+SETTLE+window and k+SETTLE+window+1. window=0 gives done at k+SETTLE with counts 0, tie=1, response=0.
- Results hold in IDLE until the next accepted start.
- start while busy=1 is ignored, not queued. start held high re-triggers in the first IDLE cycle after DONE.
- window changes after capture have no effect.
- Tie: response=0, tie=1. Saturated results still compare as counted.

Test Plan:
- clk 10 ns; osc_a period 40 ns, osc_b period 60 ns; window=120; pulse start → done at start-edge+128; count_a=30±1, count_b=20±1; response=1, tie=0, saturated=0; en_a/en_b high for exactly 128 cycles.
- Swap periods (osc_a 60 ns, osc_b 40 ns) → response=0; equal 40 ns periods, same phase → count_a==count_b, tie=1, response=0.
- CNT_W=4; osc_a period 40 ns; window=100 → count_a=15, saturated=1; osc_b held 0 → count_b=0, response=1.
- window=0 → done at start-edge+8; counts 0, tie=1; osc toggling during SETTLE is not counted.
- start pulsed again mid-COUNT, and window changed mid-COUNT → no effect on that measurement's timing or counts; exactly one done.
- rst_n low mid-COUNT → en_a/en_b/busy go 0 without waiting for clk; no done pulse; outputs 0; a subsequent start runs a clean measurement.
